ps2_mouse_packet: RTL and testbench

PS2_MOUSE_PACKET -- requirements
Module: ps2_mouse_packet

---
 rtl/ps2_mouse_pkg.sv | 27 ++
 rtl/ps2_axis_accum.sv | 46 ++++
 rtl/ps2_mouse_packet.sv | 174 +++++++++++++++++
 tb/tb_ps2_mouse_packet.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_mouse_pkg.sv
// rtl/ps2_mouse_pkg.sv - shared state encoding, protocol constants and byte-0 bit map
package ps2_mouse_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_AA = 3'd0,
        ST_WAIT_ID = 3'd1,
        ST_BYTE0   = 3'd2,
        ST_BYTE1   = 3'd3,
        ST_BYTE2   = 3'd4
    } ps2_state_e;

    localparam logic [7:0] BAT_OK = 8'hAA;
    localparam logic [7:0] DEV_ID = 8'h00;

    localparam int B0_BTN_LSB = 0;
    localparam int B0_BTN_MSB = 2;
    localparam int B0_ALIGN   = 3;
    localparam int B0_XSIGN   = 4;
    localparam int B0_YSIGN   = 5;
    localparam int B0_XOVF    = 6;
    localparam int B0_YOVF    = 7;

    function automatic logic signed [11:0] sext9(input logic [8:0] d);
        return {{3{d[8]}}, d};
    endfunction

endpackage

// File: rtl/ps2_axis_accum.sv
// rtl/ps2_axis_accum.sv - one cursor axis: signed 12-bit add, overflow skip, clamp to [0, MAX]
module ps2_axis_accum
    import ps2_mouse_pkg::*;
#(
    parameter int MAX = 639
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               upd_i,
    input  logic               ovf_i,
    input  logic signed [11:0] delta_i,
    output logic [9:0]         pos_o
);

    localparam logic [9:0]         POS_RST = 10'((MAX + 1) / 2);
    localparam logic signed [11:0] MAX_S   = 12'(MAX);

    logic [9:0]         pos_q;
    logic [9:0]         pos_d;
    logic signed [11:0] sum;

    always_comb begin
        sum   = $signed({2'b00, pos_q}) + delta_i;
        pos_d = pos_q;
        if (upd_i && !ovf_i) begin
            if (sum[11]) begin
                pos_d = '0;
            end else if (sum > MAX_S) begin
                pos_d = MAX_S[9:0];
            end else begin
                pos_d = sum[9:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q <= POS_RST;
        end else begin
            pos_q <= pos_d;
        end
    end

    assign pos_o = pos_q;

endmodule

// File: rtl/ps2_mouse_packet.sv
// rtl/ps2_mouse_packet.sv - PS/2 mouse link-up tracking, 3-byte packet framing and cursor position
module ps2_mouse_packet
    import ps2_mouse_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int X_MAX          = 639,
    parameter int Y_MAX          = 479
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_done,
    input  logic [7:0]        rx_data,
    output logic              link_up,
    output logic              pkt_valid,
    output logic [2:0]        btn,
    output logic signed [8:0] dx,
    output logic signed [8:0] dy,
    output logic              x_ovf,
    output logic              y_ovf,
    output logic [9:0]        pos_x,
    output logic [9:0]        pos_y,
    output logic              sync_err
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    ps2_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
    logic             link_up_q, link_up_d;
    logic             sync_err_q, sync_err_d;
    logic             pkt_valid_q;
    logic             pkt_fire;
    logic [2:0]       btn_q;
    logic [8:0]       dx_q, dy_q;
    logic             x_ovf_q, y_ovf_q;

    // Byte 2 is decoded straight off rx_data so results land with pkt_valid.
    logic [8:0]         pkt_dx, pkt_dy;
    logic signed [11:0] x_delta, y_delta;

    assign pkt_dx  = {b0_q[B0_XSIGN], b1_q};
    assign pkt_dy  = {b0_q[B0_YSIGN], rx_data};
    assign x_delta = sext9(pkt_dx);
    assign y_delta = -sext9(pkt_dy);

    always_comb begin
        state_d    = state_q;
        b0_d       = b0_q;
        b1_d       = b1_q;
        b2_d       = b2_q;
        link_up_d  = link_up_q;
        sync_err_d = 1'b0;
        pkt_fire   = 1'b0;
        case (state_q)
            ST_WAIT_AA: begin
                if (rx_done && rx_data == BAT_OK) state_d = ST_WAIT_ID;
            end
            ST_WAIT_ID: begin
                if (rx_done) begin
                    if (rx_data == DEV_ID) begin
                        state_d   = ST_BYTE0;
                        link_up_d = 1'b1;
                    end else if (rx_data != BAT_OK) begin
                        state_d = ST_WAIT_AA;
                    end
                end
            end
            ST_BYTE0: begin
                if (rx_done) begin
                    if (rx_data[B0_ALIGN]) begin
                        b0_d    = rx_data;
                        state_d = ST_BYTE1;
                    end else begin
                        sync_err_d = 1'b1;
                    end
                end
            end
            ST_BYTE1: begin
                if (rx_done) begin
                    b1_d    = rx_data;
                    state_d = ST_BYTE2;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = ST_BYTE0;
                    sync_err_d = 1'b1;
                    b0_d       = '0;
                end
            end
            ST_BYTE2: begin
                if (rx_done) begin
                    b2_d     = rx_data;
                    state_d  = ST_BYTE0;
                    pkt_fire = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = ST_BYTE0;
                    sync_err_d = 1'b1;
                    b0_d       = '0;
                    b1_d       = '0;
                end
            end
            default: state_d = ST_WAIT_AA;
        endcase

        if (rx_done || state_d != state_q ||
            !(state_q == ST_BYTE1 || state_q == ST_BYTE2)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_WAIT_AA;
            cnt_q       <= '0;
            b0_q        <= '0;
            b1_q        <= '0;
            b2_q        <= '0;
            link_up_q   <= 1'b0;
            sync_err_q  <= 1'b0;
            pkt_valid_q <= 1'b0;
            btn_q       <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            x_ovf_q     <= 1'b0;
            y_ovf_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            b0_q        <= b0_d;
            b1_q        <= b1_d;
            b2_q        <= b2_d;
            link_up_q   <= link_up_d;
            sync_err_q  <= sync_err_d;
            pkt_valid_q <= pkt_fire;
            if (pkt_fire) begin
                btn_q   <= b0_q[B0_BTN_MSB:B0_BTN_LSB];
                dx_q    <= pkt_dx;
                dy_q    <= pkt_dy;
                x_ovf_q <= b0_q[B0_XOVF];
                y_ovf_q <= b0_q[B0_YOVF];
            end
        end
    end

    ps2_axis_accum #(.MAX(X_MAX)) u_axis_x (
        .clk     (clk),
        .reset   (reset),
        .upd_i   (pkt_fire),
        .ovf_i   (b0_q[B0_XOVF]),
        .delta_i (x_delta),
        .pos_o   (pos_x)
    );

    ps2_axis_accum #(.MAX(Y_MAX)) u_axis_y (
        .clk     (clk),
        .reset   (reset),
        .upd_i   (pkt_fire),
        .ovf_i   (b0_q[B0_YOVF]),
        .delta_i (y_delta),
        .pos_o   (pos_y)
    );

    assign link_up   = link_up_q;
    assign pkt_valid = pkt_valid_q;
    assign sync_err  = sync_err_q;
    assign btn       = btn_q;
    assign dx        = dx_q;
    assign dy        = dy_q;
    assign x_ovf     = x_ovf_q;
    assign y_ovf     = y_ovf_q;

endmodule

// File: tb/tb_ps2_mouse_packet.sv
// tb/tb_ps2_mouse_packet.sv - vector table plus scoreboard bench for ps2_mouse_packet
module tb_ps2_mouse_packet;

    localparam int TMO = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       link_up, pkt_valid, x_ovf, y_ovf, sync_err;
    logic [2:0] btn;
    logic [8:0] dx, dy;
    logic [9:0] pos_x, pos_y;

    ps2_mouse_packet #(.TIMEOUT_CYCLES(TMO), .X_MAX(639), .Y_MAX(479)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_done   (rx_done),
        .rx_data   (rx_data),
        .link_up   (link_up),
        .pkt_valid (pkt_valid),
        .btn       (btn),
        .dx        (dx),
        .dy        (dy),
        .x_ovf     (x_ovf),
        .y_ovf     (y_ovf),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .sync_err  (sync_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] b0, b1, b2;
        logic [2:0] btn;
        logic [8:0] dx, dy;
        logic       xo, yo;
        logic [9:0] px, py;
    } vec_t;

    vec_t         vt [8];
    logic [42:0]  exp_q [$];
    int           n_vec = 0;
    int           n_bad = 0;
    int           serr_cnt = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sync_err) serr_cnt++;
        if (pkt_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pkt_valid", 64'd1, 64'd0);
            end else begin
                check("pkt_fields", {21'd0, btn, dx, dy, x_ovf, y_ovf, pos_x, pos_y},
                      {21'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [42:0] e, input int gap);
        send_byte(b0, gap);
        send_byte(b1, gap);
        exp_q.push_back(e);
        send_byte(b2, 0);
        check("latency", {63'd0, pkt_valid}, 64'd1);
        @(negedge clk);
        check("single_pulse", {63'd0, pkt_valid}, 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic do_link();
        send_byte(8'hAA, 1);
        send_byte(8'h00, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int k;
        vt[0] = '{1'b1, 8'h08, 8'h05, 8'h03, 3'b000, 9'h005, 9'h003, 1'b0, 1'b0, 10'd325, 10'd237};
        vt[1] = '{1'b1, 8'h39, 8'hFB, 8'hF0, 3'b001, 9'h1FB, 9'h1F0, 1'b0, 1'b0, 10'd315, 10'd256};
        vt[2] = '{1'b0, 8'h0E, 8'h10, 8'h20, 3'b110, 9'h010, 9'h020, 1'b0, 1'b0, 10'd331, 10'd224};
        vt[3] = '{1'b0, 8'h4A, 8'h7F, 8'h00, 3'b010, 9'h07F, 9'h000, 1'b1, 1'b0, 10'd331, 10'd224};
        vt[4] = '{1'b0, 8'h8C, 8'h00, 8'h7F, 3'b100, 9'h000, 9'h07F, 1'b0, 1'b1, 10'd331, 10'd224};
        vt[5] = '{1'b0, 8'h28, 8'h00, 8'h00, 3'b000, 9'h000, 9'h100, 1'b0, 1'b0, 10'd331, 10'd479};
        vt[6] = '{1'b0, 8'h18, 8'h00, 8'h00, 3'b000, 9'h100, 9'h000, 1'b0, 1'b0, 10'd75,  10'd479};
        vt[7] = '{1'b0, 8'h18, 8'h80, 8'h80, 3'b000, 9'h180, 9'h080, 1'b0, 1'b0, 10'd0,   10'd351};

        repeat (3) @(negedge clk);
        check("reset_state", {29'd0, link_up, pkt_valid, sync_err, btn, dx, dy, x_ovf, y_ovf, pos_x, pos_y},
              {29'd0, 1'b0, 1'b0, 1'b0, 3'b000, 9'h000, 9'h000, 1'b0, 1'b0, 10'd320, 10'd240});
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            if (vt[i].rst) begin
                do_reset();
                do_link();
                check("link_up", {63'd0, link_up}, 64'd1);
            end
            send_pkt(vt[i].b0, vt[i].b1, vt[i].b2,
                     {vt[i].btn, vt[i].dx, vt[i].dy, vt[i].xo, vt[i].yo, vt[i].px, vt[i].py}, 1);
        end

        // misaligned byte 0 is dropped with one sync_err
        s0 = serr_cnt;
        send_byte(8'h05, 2);
        check("bad_align_serr", 64'(serr_cnt - s0), 64'd1);
        send_pkt(8'h08, 8'h01, 8'h00, {3'b000, 9'h001, 9'h000, 1'b0, 1'b0, 10'd1, 10'd351}, 1);

        // inter-byte timeout after byte 1
        send_byte(8'h08, 0);
        send_byte(8'h10, 0);
        k = 0;
        while (!sync_err && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("timeout_cycle", 64'(k), 64'(TMO));
        repeat (2) @(negedge clk);
        send_pkt(8'h08, 8'h02, 8'h00, {3'b000, 9'h002, 9'h000, 1'b0, 1'b0, 10'd3, 10'd351}, 1);

        // bytes landing exactly on the expiry cycle win over the timeout
        s0 = serr_cnt;
        send_pkt(8'h08, 8'h03, 8'h00, {3'b000, 9'h003, 9'h000, 1'b0, 1'b0, 10'd6, 10'd351}, TMO - 1);
        check("coincident_no_serr", 64'(serr_cnt - s0), 64'd0);

        // X saturation, then overflow hold
        do_reset();
        do_link();
        for (int p = 0; p < 50; p++) begin
            int ex;
            ex = 320 + 127 * (p + 1);
            if (ex > 639) ex = 639;
            send_pkt(8'h08, 8'h7F, 8'h00, {3'b000, 9'h07F, 9'h000, 1'b0, 1'b0, 10'(ex), 10'd240}, 0);
        end
        send_pkt(8'h48, 8'h00, 8'h00, {3'b000, 9'h000, 9'h000, 1'b1, 1'b0, 10'd639, 10'd240}, 0);

        // reset mid-packet, with bytes arriving during reset
        send_byte(8'h08, 0);
        send_byte(8'h10, 0);
        reset = 1'b1;
        send_byte(8'hAA, 0);
        send_byte(8'h00, 0);
        reset = 1'b0;
        check("mid_reset_state", {29'd0, link_up, pkt_valid, sync_err, btn, dx, dy, x_ovf, y_ovf, pos_x, pos_y},
              {29'd0, 1'b0, 1'b0, 1'b0, 3'b000, 9'h000, 9'h000, 1'b0, 1'b0, 10'd320, 10'd240});
        send_byte(8'h08, 1);
        send_byte(8'h05, 1);
        send_byte(8'h03, 3);
        check("no_link_after_reset", {63'd0, link_up}, 64'd0);
        do_link();
        send_pkt(8'h08, 8'h05, 8'h03, {3'b000, 9'h005, 9'h003, 1'b0, 1'b0, 10'd325, 10'd237}, 1);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
